// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory
// responder (slave): one valid/ready handshake in each direction.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states, byte/half/word lanes and load extension.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; accept latches the request fields
// ST_WAIT | down-counting wait states; memory commits when count hits 0
// ST_RESP | response held until resp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input logic              clock,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic          accept;
    logic          commit;
    logic          acc_err;
    logic [1:0]    lane;
    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rd_sh;
    logic [31:0]   rdata_ld;

    logic [31:0] mem [DEPTH_WORDS];

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept   = (state == ST_IDLE) && bus.req_valid;
    assign commit   = (state == ST_WAIT) && (cnt == 4'd0);
    assign word_idx = lat_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((lat_size == 2'b01) && lat_addr[0]) ||
                      ((lat_size == 2'b10) && (lat_addr[1:0] != 2'b00));
    assign acc_err  = (lat_size == 2'b11) || misalign;
    assign lane     = lat_addr[1:0];
`else
    assign acc_err  = (lat_size == 2'b11);
    assign lane     = (lat_size == 2'b01) ? {lat_addr[1], 1'b0} :
                      (lat_size == 2'b10) ? 2'b00 : lat_addr[1:0];
`endif

    // Lane steering for stores, right-justify plus extension for loads.
    always_comb begin
        be       = 4'b0000;
        wdata_sh = lat_wdata;
        rdata_ld = 32'd0;
        rd_sh    = mem[word_idx] >> {lane, 3'b000};
        case (lat_size)
            2'b00: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{lat_wdata[7:0]}};
                rdata_ld = lat_uns ? {24'd0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{lat_wdata[15:0]}};
                rdata_ld = lat_uns ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            2'b10: begin
                be       = 4'b1111;
                rdata_ld = rd_sh;
            end
            default: ;
        endcase
    end

    // The WAIT dwell includes the commit cycle, so the counter loads the full
    // wait count and a zero-wait build still spends one cycle in WAIT.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: if (accept) begin
                state_nx = ST_WAIT;
                cnt_nx   = 4'(WAIT_CYCLES);
            end
            ST_WAIT: if (cnt == 4'd0) state_nx = ST_RESP;
                     else             cnt_nx   = cnt - 4'd1;
            ST_RESP: if (bus.resp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_uns      <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_write <= bus.req_write;
                lat_size  <= bus.req_size;
                lat_uns   <= bus.req_unsigned;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (lat_write || acc_err) ? 32'd0 : rdata_ld;
                resp_err_q   <= acc_err;
            end else if ((state == ST_RESP) && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    // Memory contents survive reset; a store only lands on its commit edge.
    always_ff @(posedge clock) begin
        if (commit && lat_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder: one instance with one wait state,
// one with three wait states for the reset-during-wait case.
module tb_dmem_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clock = ~clock;

    dmem_responder_if bus1();
    dmem_responder_if bus3();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    virtual dmem_responder_if vif;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus(input bit use3);
        if (use3) vif = bus3; else vif = bus1;
        vif.req_valid    = 1'b0;
        vif.req_write    = 1'b0;
        vif.req_size     = 2'b00;
        vif.req_unsigned = 1'b0;
        vif.req_addr     = 32'd0;
        vif.req_wdata    = 32'd0;
        vif.resp_ready   = 1'b0;
    endtask

    task automatic send_req(input string tag, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        int k;
        @(negedge clock);
        vif.req_valid    = 1'b1;
        vif.req_write    = wr;
        vif.req_size     = sz;
        vif.req_unsigned = uns;
        vif.req_addr     = addr;
        vif.req_wdata    = wd;
        for (k = 0; k < 20 && !vif.req_ready; k++) @(negedge clock);
        if (!vif.req_ready) check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clock);
        #1;
        vif.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            lat++;
            if (vif.resp_valid) break;
        end
        if (!vif.resp_valid) check_val({tag, "_resp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic take_resp(output logic [31:0] rd, output logic er);
        rd = vif.resp_rdata;
        er = vif.resp_err;
        @(negedge clock);
        vif.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        vif.resp_ready = 1'b0;
    endtask

    task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int          lat;
        logic [31:0] rd;
        logic        er;
        send_req(tag, wr, sz, uns, addr, wd);
        wait_resp(tag, lat);
        take_resp(rd, er);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;

        idle_bus(1'b1);
        idle_bus(1'b0);
        #12;
        check_val("rst_req_ready",  {31'd0, bus1.req_ready},  32'd1);
        check_val("rst_resp_valid", {31'd0, bus1.resp_valid}, 32'd0);
        check_val("rst_resp_rdata", bus1.resp_rdata,          32'd0);
        check_val("rst_resp_err",   {31'd0, bus1.resp_err},   32'd0);
        @(negedge clock);
        reset = 1'b0;

        // word store/load, byte merge and extension
        access("st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2);
        access("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
        access("st_b13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0, 2);
        access("ld_bs13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2);
        access("ld_bu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 2);
        access("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);
        access("ld_bu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h000000BE, 1'b0, 2);
        access("ld_hs12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 2);
        access("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h410, 32'h0,       32'h80ADBEEF, 1'b0, 2);

        // half store into upper lane
        access("st_w20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAABBBB, 32'h0,        1'b0, 2);
        access("st_h22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'h0,        1'b0, 2);
        access("ld_hs22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h00001234, 1'b0, 2);
        access("ld_w20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h1234BBBB, 1'b0, 2);

        // reserved size: error, no write
        access("ld_rsv",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2);
        access("st_rsv",  1'b1, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 2);
        access("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);

        // response backpressure with a competing request
        send_req("hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        wait_resp("hold", lat);
        check_val("hold_lat", 32'(lat), 32'd2);
        @(negedge clock);
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_size  = 2'b10;
        bus1.req_addr  = 32'h10;
        bus1.req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            check_val("hold_valid", {31'd0, bus1.resp_valid}, 32'd1);
            check_val("hold_rdata", bus1.resp_rdata,          32'h80ADBEEF);
            check_val("hold_ready", {31'd0, bus1.req_ready},  32'd0);
        end
        @(negedge clock);
        bus1.req_valid  = 1'b0;
        bus1.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus1.resp_ready = 1'b0;
        check_val("hs_valid_low", {31'd0, bus1.resp_valid}, 32'd0);
        access("ld_after_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2);

        // misaligned word store
        access("st_w04", 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D, 32'h0, 1'b0, 2);
`ifdef DMEM_MISALIGN_TRAP_EN
        access("st_mis06", 1'b1, 2'b10, 1'b0, 32'h06, 32'h55AA55AA, 32'h0,        1'b1, 2);
        access("ld_w04",   1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'hCAFEF00D, 1'b0, 2);
        access("ld_mis11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 2);
`else
        access("st_mis06", 1'b1, 2'b10, 1'b0, 32'h06, 32'h55AA55AA, 32'h0,        1'b0, 2);
        access("ld_w04",   1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h55AA55AA, 1'b0, 2);
        access("ld_mis11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'hFFFFBEEF, 1'b0, 2);
`endif

        // reset during WAIT on the three-wait-state instance
        idle_bus(1'b1);
        access("w3_st30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, 32'h0,        1'b0, 4);
        access("w3_ld30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'h11111111, 1'b0, 4);
        send_req("w3_drop", 1'b1, 2'b10, 1'b0, 32'h30, 32'h22222222);
        @(posedge clock);
        #1;
        check_val("w3_busy_ready", {31'd0, bus3.req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_val("w3_rst_ready", {31'd0, bus3.req_ready},  32'd1);
        check_val("w3_rst_valid", {31'd0, bus3.resp_valid}, 32'd0);
        check_val("w3_rst_rdata", bus3.resp_rdata,          32'd0);
        check_val("w3_rst_err",   {31'd0, bus3.resp_err},   32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        access("w3_ld30_old", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end
endmodule
